// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcodes, slot type and memory FSM state for the pipeline controller
package pipe_ctrl_pkg;

  localparam logic [5:0] RTYPE = 6'b101010;
  localparam logic [5:0] VLD   = 6'b100000;
  localparam logic [5:0] VSD   = 6'b100001;
  localparam logic [5:0] VBEZ  = 6'b100010;
  localparam logic [5:0] VBNEZ = 6'b100011;
  localparam logic [5:0] VNOP  = 6'b111100;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [4:0] rd;
    logic       mem;
    logic       we;
  } slot_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - compares the ID source registers against one in-flight writer slot
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  slot_t      slot,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  input  logic [4:0] src_d,
  input  logic       use_a,
  input  logic       use_b,
  input  logic       use_d,
  output logic       hit
);

  logic match_a;
  logic match_b;
  logic match_d;

  always_comb begin
    match_a = use_a && (src_a == slot.rd);
    match_b = use_b && (src_b == slot.rd);
    match_d = use_d && (src_d == slot.rd);
    hit     = slot.valid && slot.wr && (match_a || match_b || match_d);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW stall, ID branch resolve and data-memory handshake sequencing
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rD,
  input  logic [4:0] id_rA,
  input  logic [4:0] id_rB,
  input  logic       id_wrEn,
  input  logic       id_R_type,
  input  logic       id_memEn,
  input  logic       id_memwrEn,
  input  logic       id_bez,
  input  logic       id_bnez,
  input  logic       id_rD_zero,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       stall_if,
  output logic       stall_all,
  output logic       bubble_ex,
  output logic       flush_if,
  output logic       br_taken,
  output logic       mem_err
);

  slot_t      ex_slot, mem_slot, ex_nxt, mem_nxt;
  mem_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       err_set;

  logic is_store, is_load, is_branch, writer;
  logic use_a, use_b, use_d;
  logic hit_ex, hit_mem, hazard;
  logic in_req, timed_out, mem_done, mem_stall;

  always_comb begin
    is_store  = id_memEn & id_memwrEn;
    is_load   = id_memEn & ~id_memwrEn;
    is_branch = id_bez | id_bnez;
    writer    = id_wrEn | is_load;
    use_a     = id_R_type;
    use_b     = id_R_type;
    use_d     = is_store | is_branch;
  end

  hazard_cmp u_cmp_ex (
    .slot  (ex_slot),
    .src_a (id_rA),
    .src_b (id_rB),
    .src_d (id_rD),
    .use_a (use_a),
    .use_b (use_b),
    .use_d (use_d),
    .hit   (hit_ex)
  );

  hazard_cmp u_cmp_mem (
    .slot  (mem_slot),
    .src_a (id_rA),
    .src_b (id_rB),
    .src_d (id_rD),
    .use_a (use_a),
    .use_b (use_b),
    .use_d (use_d),
    .hit   (hit_mem)
  );

  // WB is never checked: the register file writes through to ID in the same cycle.
  always_comb begin
    hazard    = id_valid & (hit_ex | hit_mem);
    in_req    = (state == ST_REQ);
    timed_out = in_req & (cnt == 8'(TIMEOUT - 1));
    mem_done  = in_req & (dmem_ack | timed_out);
    mem_stall = in_req & ~mem_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
      mem_err  <= 1'b0;
    end else begin
      ex_slot  <= ex_nxt;
      mem_slot <= mem_nxt;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_err  <= mem_err | err_set;
    end
  end

  always_comb begin
    ex_nxt    = ex_slot;
    mem_nxt   = mem_slot;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    dmem_req  = in_req;
    dmem_we   = in_req & mem_slot.we;
    stall_if  = 1'b0;
    stall_all = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    br_taken  = 1'b0;

    if (mem_stall) begin
      stall_if  = 1'b1;
      stall_all = 1'b1;
      cnt_nxt   = cnt + 8'd1;
    end else begin
      cnt_nxt = '0;
      err_set = timed_out & ~dmem_ack;
      mem_nxt = ex_slot;
      if (hazard) begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
        ex_nxt    = '0;
      end else begin
        br_taken     = id_valid & (id_bez ? id_rD_zero : (id_bnez & ~id_rD_zero));
        flush_if     = br_taken;
        // Branches occupy EX as non-writers so they never raise a hazard downstream.
        ex_nxt.valid = id_valid;
        ex_nxt.wr    = writer & ~is_branch;
        ex_nxt.rd    = id_rD;
        ex_nxt.mem   = id_memEn & ~is_branch;
        ex_nxt.we    = is_store & ~is_branch;
      end
      state_nxt = (mem_nxt.valid & mem_nxt.mem) ? ST_REQ : ST_IDLE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rD = '0, id_rA = '0, id_rB = '0;
  logic       id_wrEn = 1'b0, id_R_type = 1'b0, id_memEn = 1'b0, id_memwrEn = 1'b0;
  logic       id_bez = 1'b0, id_bnez = 1'b0, id_rD_zero = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       dmem_req, dmem_we, stall_if, stall_all, bubble_ex, flush_if, br_taken, mem_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rD      (id_rD),
    .id_rA      (id_rA),
    .id_rB      (id_rB),
    .id_wrEn    (id_wrEn),
    .id_R_type  (id_R_type),
    .id_memEn   (id_memEn),
    .id_memwrEn (id_memwrEn),
    .id_bez     (id_bez),
    .id_bnez    (id_bnez),
    .id_rD_zero (id_rD_zero),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .stall_if   (stall_if),
    .stall_all  (stall_all),
    .bubble_ex  (bubble_ex),
    .flush_if   (flush_if),
    .br_taken   (br_taken),
    .mem_err    (mem_err)
  );

  // {dmem_req, dmem_we, stall_if, stall_all, bubble_ex, flush_if, br_taken}
  wire [6:0] outs = {dmem_req, dmem_we, stall_if, stall_all, bubble_ex, flush_if, br_taken};

  typedef struct packed {
    logic [5:0] op;
    logic       v;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       z;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic v, input logic [4:0] rd,
                              input logic [4:0] ra, input logic [4:0] rb, input logic z,
                              input logic ack, input logic [6:0] exp);
    vec_t r;
    r.op = op; r.v = v; r.rd = rd; r.ra = ra; r.rb = rb; r.z = z; r.ack = ack; r.exp = exp;
    return r;
  endfunction

  task automatic apply(input vec_t x);
    id_valid   = x.v;
    id_rD      = x.rd;
    id_rA      = x.ra;
    id_rB      = x.rb;
    id_rD_zero = x.z;
    dmem_ack   = x.ack;
    id_wrEn    = (x.op == RTYPE);
    id_R_type  = (x.op == RTYPE);
    id_memEn   = (x.op == VLD) || (x.op == VSD);
    id_memwrEn = (x.op == VSD);
    id_bez     = (x.op == VBEZ);
    id_bnez    = (x.op == VBNEZ);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(mk(VNOP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 7'b0));
    #2;
    tests++;
    if (outs !== 7'b0) begin
      fails++;
      $display("FAIL reset_outs: got %b expected %b", outs, 7'b0);
    end
    tests++;
    if (mem_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mem_err: got %b expected 0", mem_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_raw;
    vec_t v[10];
    v[0] = mk(RTYPE, 1, 5'd3, 5'd1, 5'd2, 0, 0, 7'b0000000);
    v[1] = mk(RTYPE, 1, 5'd4, 5'd3, 5'd0, 0, 0, 7'b0010100);
    v[2] = mk(RTYPE, 1, 5'd4, 5'd3, 5'd0, 0, 0, 7'b0010100);
    v[3] = mk(RTYPE, 1, 5'd4, 5'd3, 5'd0, 0, 0, 7'b0000000);
    v[4] = mk(VNOP,  0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000);
    v[5] = mk(RTYPE, 1, 5'd6, 5'd1, 5'd2, 0, 0, 7'b0000000);
    v[6] = mk(RTYPE, 1, 5'd7, 5'd1, 5'd2, 0, 0, 7'b0000000);
    v[7] = mk(RTYPE, 1, 5'd8, 5'd6, 5'd1, 0, 0, 7'b0010100);
    v[8] = mk(RTYPE, 1, 5'd8, 5'd6, 5'd1, 0, 0, 7'b0000000);
    v[9] = mk(VNOP,  0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000);
    for (int i = 0; i < 10; i++) begin
      apply(v[i]);
      #4;
      tests++;
      if (outs !== v[i].exp) begin
        fails++;
        $display("FAIL raw[%0d]: got %b expected %b", i, outs, v[i].exp);
      end
      next_cycle();
    end
    apply(mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0));
    next_cycle();
  endtask

  task automatic test_load_store;
    vec_t v[9];
    v[0] = mk(VLD,  1, 5'd5, 5'd1, 5'd0, 0, 0, 7'b0000000);
    v[1] = mk(VSD,  1, 5'd5, 5'd1, 5'd0, 0, 0, 7'b0010100);
    v[2] = mk(VSD,  1, 5'd5, 5'd1, 5'd0, 0, 0, 7'b1011000);
    v[3] = mk(VSD,  1, 5'd5, 5'd1, 5'd0, 0, 0, 7'b1011000);
    v[4] = mk(VSD,  1, 5'd5, 5'd1, 5'd0, 0, 1, 7'b1010100);
    v[5] = mk(VSD,  1, 5'd5, 5'd1, 5'd0, 0, 0, 7'b0000000);
    v[6] = mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000);
    v[7] = mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 1, 7'b1100000);
    v[8] = mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000);
    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      #4;
      tests++;
      if (outs !== v[i].exp) begin
        fails++;
        $display("FAIL load_store[%0d]: got %b expected %b", i, outs, v[i].exp);
      end
      next_cycle();
    end
    tests++;
    if (mem_err !== 1'b0) begin
      fails++;
      $display("FAIL load_store_mem_err: got %b expected 0", mem_err);
    end
  endtask

  task automatic test_branch;
    vec_t v[9];
    v[0] = mk(VBEZ,  1, 5'd9, 5'd0, 5'd0, 1, 0, 7'b0000011);
    v[1] = mk(VBNEZ, 1, 5'd9, 5'd0, 5'd0, 1, 0, 7'b0000000);
    v[2] = mk(VBNEZ, 1, 5'd9, 5'd0, 5'd0, 0, 0, 7'b0000011);
    v[3] = mk(RTYPE, 1, 5'd8, 5'd9, 5'd9, 0, 0, 7'b0000000);
    v[4] = mk(VBEZ,  1, 5'd8, 5'd0, 5'd0, 1, 0, 7'b0010100);
    v[5] = mk(VBEZ,  1, 5'd8, 5'd0, 5'd0, 1, 0, 7'b0010100);
    v[6] = mk(VBEZ,  1, 5'd8, 5'd0, 5'd0, 1, 0, 7'b0000011);
    v[7] = mk(VNOP,  0, 5'd0, 5'd0, 5'd0, 1, 0, 7'b0000000);
    v[8] = mk(VNOP,  0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000);
    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      #4;
      tests++;
      if (outs !== v[i].exp) begin
        fails++;
        $display("FAIL branch[%0d]: got %b expected %b", i, outs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout;
    vec_t v[4];
    int req_cycles = 0;
    int stall_cycles = 0;
    apply(mk(VLD, 1, 5'd10, 5'd1, 5'd0, 0, 0, 7'b0));
    next_cycle();
    apply(mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0));
    #4;
    tests++;
    if (mem_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_before: got %b expected 0", mem_err);
    end
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      #4;
      if (dmem_req === 1'b1) req_cycles++;
      if (stall_all === 1'b1) stall_cycles++;
      next_cycle();
    end
    tests++;
    if (req_cycles != 4) begin
      fails++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles);
    end
    tests++;
    if (stall_cycles != 3) begin
      fails++;
      $display("FAIL timeout_stall_cycles: got %0d expected 3", stall_cycles);
    end
    tests++;
    if (mem_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_mem_err: got %b expected 1", mem_err);
    end
    v[0] = mk(VSD,  1, 5'd11, 5'd1, 5'd0, 0, 0, 7'b0000000);
    v[1] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 0, 7'b0000000);
    v[2] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 1, 7'b1100000);
    v[3] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 0, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      #4;
      tests++;
      if (outs !== v[i].exp) begin
        fails++;
        $display("FAIL after_timeout[%0d]: got %b expected %b", i, outs, v[i].exp);
      end
      next_cycle();
    end
    tests++;
    if (mem_err !== 1'b1) begin
      fails++;
      $display("FAIL mem_err_sticky: got %b expected 1", mem_err);
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[6];
    v[0] = mk(VLD,  1, 5'd12, 5'd1, 5'd0, 0, 0, 7'b0000000);
    v[1] = mk(VSD,  1, 5'd13, 5'd1, 5'd0, 0, 0, 7'b0000000);
    v[2] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 1, 7'b1000000);
    v[3] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 1, 7'b1100000);
    v[4] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 1, 7'b0000000);
    v[5] = mk(VNOP, 0, 5'd0,  5'd0, 5'd0, 0, 0, 7'b0000000);
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      #4;
      tests++;
      if (outs !== v[i].exp) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, outs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    apply(mk(VLD, 1, 5'd14, 5'd1, 5'd0, 0, 0, 7'b0));
    next_cycle();
    apply(mk(VNOP, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0));
    next_cycle();
    #2;
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_req_before: got %b expected 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_req_drop: got %b expected 0", dmem_req);
    end
    tests++;
    if (mem_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_mem_err: got %b expected 0", mem_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      #4;
      tests++;
      if (outs !== 7'b0) begin
        fails++;
        $display("FAIL reset_mid_idle[%0d]: got %b expected %b", i, outs, 7'b0);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load_store();
    test_branch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
